// File: rtl/muldiv_if.sv
// +-----------------------------------------------------------------------+
// | Module   : muldiv_if                                                  |
// | Brief    : start/done request and result bundle between the control  |
// |            unit (master) and the shared multiply/divide engine       |
// |            (slave).                                                   |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
`default_nettype none

interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, op, a, b,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  start, op, a, b,
        output hi, lo, busy, done, div_zero
    );
endinterface

`default_nettype wire

// File: rtl/muldiv_unit.sv
// +-----------------------------------------------------------------------+
// | Module   : muldiv_unit                                                |
// | Brief    : Iterative signed/unsigned WIDTH x WIDTH multiply and       |
// |            WIDTH / WIDTH divide on one shared accumulator.            |
// |            mult: shift-add, LSB first; div: restoring, MSB first.     |
// |            Optional macro MULDIV_EARLY_TERM_EN: multiply leaves CALC  |
// |            as soon as the remaining multiplier bits are all zero.     |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
`default_nettype none

module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_is_div;
    logic                 r_neg_q;     // result / quotient sign
    logic                 r_neg_r;     // remainder sign (dividend sign)
    logic [2*WIDTH-1:0]   r_acc;       // mult: product; div: {remainder, quotient}
    logic [2*WIDTH-1:0]   r_mcand;     // multiplicand, shifted left each cycle
    logic [WIDTH-1:0]     r_opb;       // multiplier (shifted right) or divisor
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_div_zero;

    logic                 w_sgn_op;
    logic                 w_div_zero;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic [WIDTH:0]       w_shift;
    logic                 w_ge;
    logic [WIDTH-1:0]     w_diff;
    logic [WIDTH-1:0]     w_rem_next;
    logic [2*WIDTH-1:0]   w_div_next;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_rem;
    logic                 w_last;

    // Operand conditioning at issue: magnitudes for signed ops, raw otherwise
    assign w_sgn_op   = ~bus.op[0];
    assign w_div_zero = bus.op[1] && (bus.b == '0);
    assign w_abs_a    = (w_sgn_op && bus.a[WIDTH-1]) ? (-bus.a) : bus.a;
    assign w_abs_b    = (w_sgn_op && bus.b[WIDTH-1]) ? (-bus.b) : bus.b;

    // One restoring-division step: shift {R,Q} left, subtract divisor if it fits.
    // The shifted remainder needs one extra bit; the difference always fits WIDTH.
    assign w_shift    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_ge       = (w_shift >= {1'b0, r_opb});
    assign w_diff     = w_shift[WIDTH-1:0] - r_opb;
    assign w_rem_next = w_ge ? w_diff : w_shift[WIDTH-1:0];
    assign w_div_next = {w_rem_next, r_acc[WIDTH-2:0], w_ge};

    // Sign fix-up; negating the most-negative quotient wraps onto itself
    assign w_prod = r_neg_q ? (-r_acc) : r_acc;
    assign w_quo  = r_neg_q ? (-r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_r ? (-r_acc[2*WIDTH-1:WIDTH]) : r_acc[2*WIDTH-1:WIDTH];

`ifdef MULDIV_EARLY_TERM_EN
    // Multiply may stop once no set multiplier bits remain beyond the current one
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1)) ||
                    (!r_is_div && (r_opb[WIDTH-1:1] == '0));
`else
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));
`endif

    // Control FSM and datapath registers with registered handshake outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_acc      <= '0;
            r_mcand    <= '0;
            r_opb      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        if (w_div_zero) begin
                            r_state    <= S_DONE;
                            r_done     <= 1'b1;
                            r_div_zero <= 1'b1;
                        end else begin
                            r_state    <= S_CALC;
                            r_busy     <= 1'b1;
                            r_div_zero <= 1'b0;
                            r_is_div   <= bus.op[1];
                            r_neg_q    <= w_sgn_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                            r_neg_r    <= w_sgn_op && bus.a[WIDTH-1];
                            r_acc      <= bus.op[1] ? {{WIDTH{1'b0}}, w_abs_a} : '0;
                            r_mcand    <= {{WIDTH{1'b0}}, w_abs_a};
                            r_opb      <= w_abs_b;
                            r_cnt      <= '0;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    if (r_is_div) begin
                        r_acc <= w_div_next;
                    end else begin
                        if (r_opb[0]) begin
                            r_acc <= r_acc + r_mcand;
                        end
                        r_mcand <= r_mcand << 1;
                        r_opb   <= r_opb >> 1;
                    end
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (r_is_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end else begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.div_zero = r_div_zero;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// +-----------------------------------------------------------------------+
// | Module   : tb_muldiv_unit                                             |
// | Brief    : Directed scoreboard bench for muldiv_unit (WIDTH=32).      |
// |            Honours MULDIV_EARLY_TERM_EN in its latency model.         |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_muldiv_unit;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        logic         busy_exp;
        int           lat;
        int           t0;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic [W-1:0] last_hi = '0;
    logic [W-1:0] last_lo = '0;

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour, computed from wide host arithmetic
    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t         e;
        longint       p;
        logic [63:0]  up;
        logic [W-1:0] mb;
        int           h;
        e.hi = last_hi;
        e.lo = last_lo;
        e.dz = 1'b0;
        e.busy_exp = 1'b1;
        e.t0 = 0;
        e.lat = W + 2;
        case (op)
            2'b00: begin
                p = longint'($signed(a)) * longint'($signed(b));
                {e.hi, e.lo} = p;
            end
            2'b01: begin
                up = {32'd0, a} * {32'd0, b};
                {e.hi, e.lo} = up;
            end
            2'b10: begin
                if (b == '0) begin
                    e.dz = 1'b1;
                end else begin
                    p = longint'($signed(a)) / longint'($signed(b));
                    e.lo = p[W-1:0];
                    p = longint'($signed(a)) % longint'($signed(b));
                    e.hi = p[W-1:0];
                end
            end
            default: begin
                if (b == '0) begin
                    e.dz = 1'b1;
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
        endcase
        if (e.dz) begin
            e.lat = 1;
            e.busy_exp = 1'b0;
        end
`ifdef MULDIV_EARLY_TERM_EN
        if (!op[1]) begin
            mb = (op == 2'b00 && b[W-1]) ? -b : b;
            h = 0;
            for (int i = 0; i < W; i++) if (mb[i]) h = i + 1;
            e.lat = ((h == 0) ? 1 : h) + 2;
        end
`else
        mb = '0;
        h = 0;
`endif
        return e;
    endfunction

    // Drive a one-cycle start; caller stands between edges
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e = model(op, a, b);
        last_hi = e.hi;
        last_lo = e.lo;
        bus.start = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        e.t0 = cyc;
        exp_q.push_back(e);
    endtask

    // Wait (bounded) for done, then score the oldest expectation
    task automatic wait_done(input string tag);
        exp_t e;
        int   n;
        logic seen_busy;
        n = 0;
        seen_busy = 1'b0;
        while (n < 200) begin
            @(negedge clk);
            if (bus.busy) seen_busy = 1'b1;
            if (bus.done) break;
            n++;
        end
        e = exp_q.pop_front();
        chk({tag, ".done"}, 64'(bus.done), 64'(1));
        chk({tag, ".hi"}, 64'(bus.hi), 64'(e.hi));
        chk({tag, ".lo"}, 64'(bus.lo), 64'(e.lo));
        chk({tag, ".div_zero"}, 64'(bus.div_zero), 64'(e.dz));
        chk({tag, ".latency"}, 64'(cyc - e.t0 + 1), 64'(e.lat));
        chk({tag, ".busy"}, 64'(seen_busy), 64'(e.busy_exp));
    endtask

    initial begin
        logic seen_done;
        reset = 1'b0;
        bus.start = 1'b1;
        bus.op = 2'b00;
        bus.a = 32'd6;
        bus.b = 32'd7;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.hi", 64'(bus.hi), 64'(0));
        chk("rst.lo", 64'(bus.lo), 64'(0));
        chk("rst.busy", 64'(bus.busy), 64'(0));
        chk("rst.done", 64'(bus.done), 64'(0));
        reset = 1'b1;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.idle", 64'({bus.busy, bus.done}), 64'(0));

        issue(2'b00, 32'd6, 32'd7);                 wait_done("smul6x7");
        @(negedge clk);
        issue(2'b00, 32'hFFFF_FFFD, 32'd5);         wait_done("smul-3x5");
        @(negedge clk);
        issue(2'b01, 32'hFFFF_FFFD, 32'd5);         wait_done("umul");
        @(negedge clk);
        issue(2'b00, 32'h8000_0000, 32'h8000_0000); wait_done("smul_minneg");
        @(negedge clk);
        issue(2'b10, 32'hFFFF_FFF9, 32'd2);         wait_done("sdiv-7/2");
        @(negedge clk);
        issue(2'b11, 32'hFFFF_FFF9, 32'd2);         wait_done("udiv");
        @(negedge clk);
        issue(2'b10, 32'd100, 32'hFFFF_FFF9);       wait_done("sdiv100/-7");
        @(negedge clk);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF); wait_done("sdiv_wrap");
        // Back-to-back: next start driven in the DONE cycle
        issue(2'b11, 32'd9, 32'd3);                 wait_done("b2b");
        @(negedge clk);
        issue(2'b11, 32'h1234_5678, 32'd0);         wait_done("udiv0");
        issue(2'b10, 32'd5, 32'd0);                 wait_done("sdiv0_b2b");
        @(negedge clk);

        // Start pulse in mid-CALC must be ignored
        issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (5) @(negedge clk);
        bus.start = 1'b1;
        bus.op = 2'b11;
        bus.b = 32'd0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done("midcalc");
        @(negedge clk);

        // Reset during CALC discards the operation
        issue(2'b00, 32'd1234, 32'd5678);
        repeat (9) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        chk("rstcalc.busy", 64'(bus.busy), 64'(0));
        chk("rstcalc.done", 64'(bus.done), 64'(0));
        chk("rstcalc.hi", 64'(bus.hi), 64'(0));
        chk("rstcalc.lo", 64'(bus.lo), 64'(0));
        void'(exp_q.pop_front());
        last_hi = '0;
        last_lo = '0;
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen_done = 1'b1;
        end
        chk("rstcalc.quiet", 64'(seen_done), 64'(0));

        issue(2'b01, 32'd5, 32'd1);                 wait_done("early_b1");
        @(negedge clk);
        issue(2'b01, 32'd5, 32'h8000_0000);         wait_done("early_bmsb");
        @(negedge clk);
        issue(2'b00, 32'd77, 32'd0);                wait_done("early_b0");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
